// File: rtl/mux16_rr_arbiter.sv
// 16-requester round-robin arbiter driving a shared 16:1 data mux, with registered grant and data.
// Define MUX16_ARB_TIMEOUT_EN to limit each grant to MAX_HOLD cycles while other requesters wait.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] in,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        out,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      state_q, state_d;
  logic [15:0] gnt_q, gnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        out_q, out_d;
  logic        out_valid_q, out_valid_d;

  logic        win_found;
  logic [3:0]  win_idx;
  logic        new_grant;
  logic        grant_end;
  logic        timeout_hit;

  assign busy = (state_q == StGrant);

  // First set request at or after ptr, wrapping mod 16.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 0; i < 16; i++) begin
      if (!win_found && req[ptr_q + 4'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 4'(i);
      end
    end
  end

  assign grant_end = !req[sel_q] || timeout_hit;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          new_grant = 1'b1;
        end
      end
      StGrant: begin
        if (grant_end) begin
          // On timeout ptr already points past sel, so the holder only wins again if alone.
          if (win_found) begin
            new_grant = 1'b1;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

    if (new_grant) begin
      state_d = StGrant;
      sel_d   = win_idx;
      gnt_d   = 16'(1) << win_idx;
      ptr_d   = win_idx + 4'd1;
    end

    out_d       = busy ? in[sel_q] : 1'b0;
    out_valid_d = busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MUX16_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign timeout_hit = (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (new_grant) begin
      hold_d = '0;
    end else if (busy) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifndef SYNTHESIS
  gnt_matches_sel: assert property (@(posedge clk) disable iff (!rst_n)
    busy ? (gnt == (16'(1) << sel)) : (gnt == '0));
`endif

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed-vector bench for mux16_rr_arbiter; expectations adapt to MUX16_ARB_TIMEOUT_EN.
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] in;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        out;
  logic        out_valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  mux16_rr_arbiter #(
    .MAX_HOLD(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .in       (in),
    .gnt      (gnt),
    .sel      (sel),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle #1 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0000;
    in    = 16'h3f0a;
    #12;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_sel", 32'(sel), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_out", 32'(out), 32'h0);
    check_eq("rst_ovld", 32'(out_valid), 32'h0);
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_gnt", 32'(gnt), 32'h0);
      check_eq("idle_busy", 32'(busy), 32'h0);
      check_eq("idle_ovld", 32'(out_valid), 32'h0);
    end

    // Top requester, then wrap to search from 0.
    req = 16'h8000;
    tick();
    check_eq("r15_gnt", 32'(gnt), 32'h8000);
    check_eq("r15_sel", 32'(sel), 32'hf);
    check_eq("r15_busy", 32'(busy), 32'h1);
    check_eq("r15_ovld_lag", 32'(out_valid), 32'h0);
    req = 16'h0000;
    tick();
    check_eq("r15_end_gnt", 32'(gnt), 32'h0);
    check_eq("r15_end_busy", 32'(busy), 32'h0);
    check_eq("r15_sel_hold", 32'(sel), 32'hf);
    check_eq("r15_out", 32'(out), 32'h0);
    check_eq("r15_ovld", 32'(out_valid), 32'h1);
    req = 16'h1000;
    tick();
    check_eq("r12_sel", 32'(sel), 32'hc);
    check_eq("r12_gnt", 32'(gnt), 32'h1000);
    check_eq("r12_ovld_lag", 32'(out_valid), 32'h0);
    tick();
    check_eq("r12_out", 32'(out), 32'h1);
    check_eq("r12_ovld", 32'(out_valid), 32'h1);
    req = 16'h0000;
    tick();
    tick();
    check_eq("r12_idle_ovld", 32'(out_valid), 32'h0);

    // Two requesters from ptr=13: bit 0 wins first.
    req = 16'h0041;
    tick();
    check_eq("alt_gnt0", 32'(gnt), 32'h0001);
    check_eq("alt_sel0", 32'(sel), 32'h0);
    for (int i = 0; i < 7; i++) tick();
    check_eq("alt_hold0", 32'(gnt), 32'h0001);
    tick();
`ifdef MUX16_ARB_TIMEOUT_EN
    check_eq("alt_to_gnt6", 32'(gnt), 32'h0040);
    check_eq("alt_to_sel6", 32'(sel), 32'h6);
`else
    check_eq("alt_keep_gnt0", 32'(gnt), 32'h0001);
    req = 16'h0040;
    tick();
    check_eq("alt_drop_sel6", 32'(sel), 32'h6);
    check_eq("alt_drop_busy", 32'(busy), 32'h1);
`endif
    tick();
    check_eq("alt_out6", 32'(out), 32'h0);
    check_eq("alt_ovld6", 32'(out_valid), 32'h1);

    // Asynchronous reset mid-grant, released between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_gnt", 32'(gnt), 32'h0);
    check_eq("arst_sel", 32'(sel), 32'h0);
    check_eq("arst_busy", 32'(busy), 32'h0);
    check_eq("arst_ovld", 32'(out_valid), 32'h0);
    #1;
    rst_n = 1'b1;
    req   = 16'h0140;
    tick();
    check_eq("post_rst_sel", 32'(sel), 32'h6);
    check_eq("post_rst_gnt", 32'(gnt), 32'h0040);

    // Short grant: busy for 3 cycles, out_valid trails by one.
    req = 16'h0000;
    tick();
    check_eq("short_pre_busy", 32'(busy), 32'h0);
    req = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("short_busy", 32'(busy), 32'h1);
      check_eq("short_sel", 32'(sel), 32'h1);
    end
    req = 16'h0000;
    tick();
    check_eq("short_end_busy", 32'(busy), 32'h0);
    check_eq("short_end_ovld", 32'(out_valid), 32'h1);
    tick();
    check_eq("short_ovld_low", 32'(out_valid), 32'h0);

    // Single requester held 20 cycles: grant never gaps, with or without timeout.
    req = 16'h0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("single_gnt", 32'(gnt), 32'h0010);
      check_eq("single_busy", 32'(busy), 32'h1);
    end

    // Handover on the same edge without an idle cycle.
    req = 16'h0011;
    tick();
    check_eq("hand_pre_sel", 32'(sel), 32'h4);
    req = 16'h0001;
    tick();
    check_eq("hand_sel", 32'(sel), 32'h0);
    check_eq("hand_gnt", 32'(gnt), 32'h0001);
    check_eq("hand_busy", 32'(busy), 32'h1);
    req = 16'h0000;
    tick();
    check_eq("final_gnt", 32'(gnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive grant cycles per requester (range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  16  request per requester; bit i = requester i.
REQ-005 Port: in  input  16  data bit per requester; bit i = requester i's data.
REQ-006 Port: gnt  output  16  registered one-hot grant; all-zero when idle.
REQ-007 Port: sel  output  4  registered index of granted requester; drives the shared 16:1 select.
REQ-008 Port: out  output  1  registered data of granted requester.
REQ-009 Port: out_valid  output  1  high when out carries granted data.
REQ-010 Port: busy  output  1  high in state GRANT.

Function
REQ-011 FSM states: IDLE, GRANT; busy = (state == GRANT).
REQ-012 IDLE, req == 0 -> stay IDLE; gnt = 0, sel holds last value.
REQ-013 IDLE, req != 0 -> GRANT next edge; winner = first set bit searching ptr, ptr+1, ... mod 16.
REQ-014 ptr is a 4-bit round-robin pointer; on every new grant to index k, ptr <= k+1 mod 16 (15 wraps to 0).
REQ-015 Grant latency: req sampled at edge N -> gnt/sel valid after edge N (visible in cycle N+1).
REQ-016 gnt == (1 << sel) whenever busy; gnt == 0 whenever not busy.
REQ-017 hold_cnt (8 bits) clears on each new grant, increments each GRANT cycle.
REQ-018 Grant ends when req[sel] == 0, or (timeout enabled) when hold_cnt == MAX_HOLD-1 with req[sel] still high.
REQ-019 End of grant, other req bits set -> grant next winner from ptr on the same edge, no idle cycle.
REQ-020 End of grant by timeout, only req[sel] set -> re-grant same index; hold_cnt clears.
REQ-021 End of grant, req == 0 -> IDLE.
REQ-022 Simultaneous requests: round-robin order only; no fixed priority beyond search from ptr.
REQ-023 out <= in[sel] each edge while busy, else 0; out_valid <= busy (one-cycle lag from gnt).
REQ-024 Requests on non-granted bits while busy do not affect gnt, sel or hold_cnt.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE, gnt 0, sel 0, ptr 0, hold_cnt 0, out 0, out_valid 0, busy 0.
REQ-026 Reset mid-grant aborts immediately; the first grant after release follows REQ-013 with ptr 0.
REQ-027 Deassertion of rst_n takes effect on the first rising clk edge after release.

Configuration
REQ-028 Macro MUX16_ARB_TIMEOUT_EN defined: REQ-018 timeout and REQ-020 active; MAX_HOLD honoured.
REQ-029 Macro MUX16_ARB_TIMEOUT_EN undefined: grant ends only when req[sel] drops; MAX_HOLD ignored; hold_cnt may be omitted.

Verification
REQ-030 Reset, req=16'h0000 for 5 cycles -> gnt=0, busy=0, out_valid=0 throughout.
REQ-031 req=16'h0041 held, in=16'h3f0a -> gnt 16'h0001 (sel 0), then 16'h0040 (sel 6) and so on in alternation; with timeout on, MAX_HOLD=8 -> each grant lasts 8 cycles; out follows in[0]=0, in[6]=0.
REQ-032 req=16'h8000 from ptr=0 -> sel=4'hf; on release, ptr=0 (wrap); then req=16'h1000 -> sel=4'hc, out=in[12]=1 for in=16'h3f0a, one cycle after gnt.
REQ-033 req=16'h0002 dropped after 3 cycles, req=16'h0000 -> busy high 3 cycles, then IDLE; out_valid low one cycle after busy falls.
REQ-034 rst_n pulsed low mid-grant at sel=4'h6 -> gnt=0, sel=0 immediately (no clock edge); next grant searches from 0.
REQ-035 Single requester req=16'h0010 held 20 cycles, MAX_HOLD=8: timeout on -> re-grant at cycles 8 and 16 (hold_cnt clears), gnt stays 16'h0010; timeout off -> single uninterrupted grant.
